cntry_car_detector: RTL and testbench

//  Country-road vehicle detector: the sensing end of the traffic signal controller's x input.

---
 rtl/cntry_car_detector.sv | 167 ++++++++++++++++
 tb/tb_cntry_car_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cntry_car_detector.sv
// Country-road car detector: synchronizes and debounces the loop sensor, queues cars, drives x.
// Optional stuck-sensor detection is enabled by defining SENSOR_STUCK_EN.
module cntry_car_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned MAX_CARS        = 15,
    parameter int unsigned DEPART_CYCLES   = 2,
    parameter int unsigned STUCK_CYCLES    = 64
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_sensor_raw,
    input  logic [1:0]       i_cntry,
    output logic             o_x,
    output logic [CNT_W-1:0] o_car_count,
    output logic             o_overflow,
    output logic             o_sensor_fault
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DEP_W = $clog2(DEPART_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEP_W-1:0] DEP_LAST  = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CARS);
    localparam logic [1:0]       CNTRY_GRN = 2'd2;

    if (DEBOUNCE_CYCLES < 1 || DEPART_CYCLES < 1 || STUCK_CYCLES < 1 ||
        MAX_CARS > (2 ** CNT_W) - 1) begin : g_bad_params
        $error("cntry_car_detector: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StWaiting, StDraining} state_e;

    logic             r_s1, r_s2;
    logic             r_filt, r_filt_d;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEP_W-1:0] r_dep_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    state_e           r_state;

    logic             w_fault;
    logic             w_arrival;
    logic             w_green;
    logic             w_nonzero;
    logic             w_depart;
    logic [CNT_W-1:0] w_count_d;
    logic             w_ovf_d;
    state_e           w_state_d;

    // Sync chain and debounce filter: filtered level follows s2 only after a stable run.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_filt    <= 1'b0;
            r_filt_d  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_s1     <= i_sensor_raw;
            r_s2     <= r_s1;
            r_filt_d <= r_filt;
            if (r_s2 != r_filt) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_filt    <= r_s2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

`ifdef SENSOR_STUCK_EN
    localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

    logic [STK_W-1:0] r_stuck_cnt;
    logic             r_fault;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else if (!r_filt) begin
            r_stuck_cnt <= '0;
        end else if (r_stuck_cnt == STK_LAST) begin
            r_fault <= 1'b1;
        end else begin
            r_stuck_cnt <= r_stuck_cnt + 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign w_arrival = r_filt & ~r_filt_d & ~w_fault;
    assign w_green   = (i_cntry == CNTRY_GRN);
    assign w_nonzero = (r_count != '0);
    assign w_depart  = w_green & w_nonzero & (r_dep_cnt == DEP_LAST);

    // Partial GREEN time is discarded whenever GREEN drops or the queue empties.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_dep_cnt <= '0;
        end else if (w_green && w_nonzero && !w_depart) begin
            r_dep_cnt <= r_dep_cnt + 1'b1;
        end else begin
            r_dep_cnt <= '0;
        end
    end

    always_comb begin
        w_count_d = r_count;
        w_ovf_d   = r_ovf;
        if (w_arrival && !w_depart) begin
            if (r_count == CNT_MAX) begin
                w_ovf_d = 1'b1;
            end else begin
                w_count_d = r_count + 1'b1;
            end
        end else if (w_depart && !w_arrival) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_count_d != '0) begin
                    w_state_d = w_green ? StDraining : StWaiting;
                end
            end
            StWaiting, StDraining: begin
                if (w_count_d == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_state_d = w_green ? StDraining : StWaiting;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_state <= StIdle;
        end else begin
            r_count <= w_count_d;
            r_ovf   <= w_ovf_d;
            r_state <= w_state_d;
        end
    end

    assign o_x            = (r_state != StIdle);
    assign o_car_count    = r_count;
    assign o_overflow     = r_ovf;
    assign o_sensor_fault = w_fault;

endmodule

// File: tb/tb_cntry_car_detector.sv
// Directed bench for cntry_car_detector: pulse table plus hand-written multi-cycle sequences.
module tb_cntry_car_detector;

    logic       clk;
    logic       clr;
    logic       raw;
    logic [1:0] cntry;
    logic       x;
    logic [3:0] car_count;
    logic       overflow;
    logic       sensor_fault;

    int n_tests;
    int n_fail;
    int exp_cnt;

    typedef struct {
        int width;
        int exp_count;
    } pulse_vec_t;

    pulse_vec_t vecs[6];

    cntry_car_detector dut (
        .i_clk         (clk),
        .i_clr         (clr),
        .i_sensor_raw  (raw),
        .i_cntry       (cntry),
        .o_x           (x),
        .o_car_count   (car_count),
        .o_overflow    (overflow),
        .o_sensor_fault(sensor_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int width);
        raw = 1'b1;
        repeat (width) tick();
        raw = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        raw     = 1'b0;
        cntry   = 2'd0;
        clr     = 1'b1;

        vecs[0] = '{width: 1,  exp_count: 1};
        vecs[1] = '{width: 2,  exp_count: 1};
        vecs[2] = '{width: 3,  exp_count: 2};
        vecs[3] = '{width: 5,  exp_count: 3};
        vecs[4] = '{width: 2,  exp_count: 3};
        vecs[5] = '{width: 10, exp_count: 4};

        repeat (2) tick();
        check("reset_count", 32'(car_count), 0);
        check("reset_x", 32'(x), 0);
        check("reset_overflow", 32'(overflow), 0);
        check("reset_fault", 32'(sensor_fault), 0);
        clr = 1'b0;
        tick();

        // Arrival latency: raw high before E0, count moves at E0+5.
        raw = 1'b1;
        repeat (5) tick();
        check("latency_early_count", 32'(car_count), 0);
        check("latency_early_x", 32'(x), 0);
        tick();
        check("latency_count", 32'(car_count), 1);
        check("latency_x", 32'(x), 1);
        repeat (4) tick();
        raw = 1'b0;
        repeat (10) tick();
        check("held_single_arrival", 32'(car_count), 1);

        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].width);
            check($sformatf("pulse%0d_w%0d_count", i, vecs[i].width), 32'(car_count),
                  32'(vecs[i].exp_count));
            check($sformatf("pulse%0d_x", i), 32'(x), 32'(vecs[i].exp_count != 0));
        end

        for (int i = 0; i < 20; i++) begin
            raw = ~raw;
            tick();
        end
        raw = 1'b0;
        repeat (10) tick();
        check("toggle_no_arrival", 32'(car_count), 4);

        // Drain at one car per two GREEN clocks.
        cntry = 2'd2;
        tick();
        check("drain_first_clk", 32'(car_count), 4);
        exp_cnt = 4;
        while (exp_cnt > 0) begin
            tick();
            if (exp_cnt != 4) tick();
            exp_cnt--;
            check($sformatf("drain_to_%0d", exp_cnt), 32'(car_count), 32'(exp_cnt));
        end
        check("drain_x_low", 32'(x), 0);
        cntry = 2'd0;
        tick();

        pulse(4);
        check("regreen_setup", 32'(car_count), 1);
        cntry = 2'd2;
        tick();
        cntry = 2'd0;
        repeat (6) tick();
        check("short_green_count", 32'(car_count), 1);
        check("short_green_x", 32'(x), 1);

        exp_cnt = 1;
        while (exp_cnt < 15) begin
            pulse(4);
            exp_cnt++;
        end
        check("fill_count", 32'(car_count), 15);
        check("fill_no_overflow", 32'(overflow), 0);
        pulse(4);
        check("overflow_count", 32'(car_count), 15);
        check("overflow_flag", 32'(overflow), 1);

        // Departures at E0+1, E0+3, E0+5, E0+7; arrival lands on E0+5.
        raw   = 1'b1;
        cntry = 2'd2;
        repeat (6) tick();
        check("coincide_count", 32'(car_count), 13);
        repeat (2) tick();
        check("coincide_next_depart", 32'(car_count), 12);
        check("coincide_x", 32'(x), 1);
        cntry = 2'd0;
        raw   = 1'b0;
        repeat (10) tick();
        check("overflow_sticky", 32'(overflow), 1);
        check("after_coincide_count", 32'(car_count), 12);

        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("async_clr_count", 32'(car_count), 0);
        check("async_clr_x", 32'(x), 0);
        check("async_clr_overflow", 32'(overflow), 0);
        #3 clr = 1'b0;
        tick();
        check("post_clr_count", 32'(car_count), 0);

        raw = 1'b1;
        repeat (70) tick();
`ifdef SENSOR_STUCK_EN
        check("stuck_fault", 32'(sensor_fault), 1);
        check("stuck_first_arrival", 32'(car_count), 1);
        raw = 1'b0;
        repeat (10) tick();
        pulse(4);
        check("stuck_arrival_ignored", 32'(car_count), 1);
        cntry = 2'd2;
        repeat (4) tick();
        check("stuck_drain_count", 32'(car_count), 0);
        check("stuck_fault_sticky", 32'(sensor_fault), 1);
        cntry = 2'd0;
`else
        check("no_stuck_fault", 32'(sensor_fault), 0);
        check("long_high_arrival", 32'(car_count), 1);
        raw = 1'b0;
        repeat (10) tick();
        pulse(4);
        check("later_arrival_count", 32'(car_count), 2);
        check("fault_tied_low", 32'(sensor_fault), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
